dff_pipe: RTL and testbench
===========================

Name: dff_pipe

Overview:
Parametrised pipeline of D flip-flops: a WIDTH-bit data path DEPTH stages deep, with a per-stage valid bit, a global advance enable, a synchronous flush and a selectable tap output.
Generalises the single-bit resettable D flip-flop to width, depth, stall and flush.
Used as a configurable delay line or retiming stage between datapath blocks.
It also keeps a registered count of occupied stages for flow-control logic.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 4, number of register stages (>=1)
RST_VAL, 0, value loaded into every data stage on reset (WIDTH bits)

Ports:
CK  input  1  clock; all state updates on the rising edge
RN  input  1  synchronous active-low reset, sampled on the rising edge of CK
EN  input  1  advance: pipeline shifts one stage when 1, holds when 0
CLR  input  1  synchronous flush: clears all valid bits
D  input  WIDTH  data into stage 0
DV  input  1  valid qualifier for D
TAP_SEL  input  TW  stage index for the tap output; TW = max(1, clog2(DEPTH))
Q  output  WIDTH  data of stage DEPTH-1 (registered)
QV  output  1  valid of stage DEPTH-1 (registered)
TAP_Q  output  WIDTH  data of stage TAP_SEL (combinational mux of registers)
TAP_V  output  1  valid of stage TAP_SEL
OCC  output  CW  registered count of valid stages, 0..DEPTH; CW = clog2(DEPTH+1)

Behaviour:
- One clock is used. Reset is synchronous and active-low. The clock port is named CK and the reset port is named RN.
- Priority at each rising CK: RN=0 > CLR=1 > EN=1 > hold.
- RN=0 sets the following:
  - every data stage = RST_VAL
  - every valid bit = 0
  - OCC = 0
  - Q = RST_VAL, QV = 0
- RN is not in any sensitivity path. Reset asserted between edges has no effect until the next rising CK.
- CLR=1 (with RN=1):
  - all valid bits go to 0 and OCC goes to 0
  - data registers hold their values
  - D/DV presented in the same cycle are discarded, even if EN=1
- EN=1 (with RN=1, CLR=0):
  - stage0 <= {D, DV}
  - stage i <= stage i-1 for i = 1..DEPTH-1
  - the shift happens regardless of DV, so bubbles (DV=0) propagate as invalid entries
- EN=0 (with RN=1, CLR=0): all registers hold, including OCC.
- Latency: a word accepted with EN=1 at edge k appears on Q/QV after the edge of the DEPTH-th EN=1 cycle counting from k. With EN held at 1, that is DEPTH cycles. EN=0 cycles stretch the latency one-for-one.
- OCC update on an EN=1 cycle: OCC <= OCC + DV - valid[DEPTH-1].
  - The update is computed in CW+1 bits and never wraps.
  - OCC must always equal the popcount of the valid bits.
  - Full (OCC=DEPTH) is not a stall condition. With DV=1 the oldest entry shifts out as the new one shifts in, and OCC stays at DEPTH.
- Tap output:
  - TAP_Q/TAP_V = stage TAP_SEL data/valid; stage 0 is the youngest.
  - TAP_SEL >= DEPTH (out of range) drives TAP_Q = 0 and TAP_V = 0.
  - The tap is combinational from TAP_SEL, with no added latency.
- DEPTH=1: stage 0 is also the output stage, TAP_SEL is 1 bit wide and only TAP_SEL=0 is in range. In an EN=1 cycle, OCC <= DV.
- Reset mid-stream: all in-flight data is lost. Outputs take reset values after that edge, and normal operation resumes on the next edge with RN=1.
- Combinational paths from D/DV/EN/CLR to any output are not permitted. Only TAP_SEL may reach TAP_Q/TAP_V combinationally.

Test Plan:
1. Reset. Hold RN=0 for 2 edges with D=8'hFF, DV=1, EN=1 -> Q=RST_VAL(8'h00), QV=0, OCC=0. Release RN, apply D=8'hA5, DV=1 for 1 cycle, then DV=0 -> Q=8'hA5 with QV=1 exactly 4 edges later.
2. Stream with bubbles. DEPTH=4, EN=1, drive D=1,2,3,4,5 with DV=1,0,1,1,0 -> Q sequence 1,2,3,4,5 with QV 1,0,1,1,0, each delayed 4 cycles. OCC follows 1,1,2,3,2,...
3. Stall. After loading 8'h11 and 8'h22 (DV=1), hold EN=0 for 3 cycles -> all outputs constant and OCC=2. Resume EN=1 -> 8'h11 reaches Q after 2 more EN cycles (4 EN cycles total).
4. Flush priority. Fill to OCC=4, then assert CLR=1, EN=1, D=8'h77, DV=1 in one cycle -> OCC=0, QV=0, all TAP_V=0. The word 8'h77 never appears with valid=1.
5. Full steady state. Keep DV=1, EN=1 for 10 cycles -> OCC saturates at 4 and never reads 5 or wraps. Q lags D by 4 cycles.
6. Tap and bounds. After loading 8'h10, 8'h20, 8'h30 (DV=1):
   - TAP_SEL=0 -> 8'h30/1
   - TAP_SEL=2 -> 8'h10/1
   - TAP_SEL=3 -> TAP_V=0
   - With DEPTH=3, TAP_SEL=3 -> TAP_Q=0, TAP_V=0. Also rerun with DEPTH=1, WIDTH=1.

Source files
------------

// File: rtl/dff_pipe.sv
// ============================================================================
// Module   : dff_pipe
// Purpose  : WIDTH x DEPTH D-flip-flop pipeline with per-stage valid, advance
//            enable, synchronous flush, tap mux and occupancy counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dff_pipe #(
  parameter int              WIDTH   = 8,
  parameter int              DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int             TW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int             CW      = $clog2(DEPTH + 1)
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             EN,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic             DV,
  input  logic [TW-1:0]    TAP_SEL,
  output logic [WIDTH-1:0] Q,
  output logic             QV,
  output logic [WIDTH-1:0] TAP_Q,
  output logic             TAP_V,
  output logic [CW-1:0]    OCC
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic             r_vld  [DEPTH];
  logic [CW-1:0]    r_occ;
  logic [CW:0]      w_occ_sum;
  logic [WIDTH-1:0] w_tap_q;
  logic             w_tap_v;

  // One extra bit keeps the +DV/-leaving arithmetic from wrapping at full.
  assign w_occ_sum = {1'b0, r_occ} + {{CW{1'b0}}, DV} - {{CW{1'b0}}, r_vld[DEPTH-1]};

  always_ff @(posedge CK) begin
    if (!RN) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= RST_VAL;
        r_vld[i]  <= 1'b0;
      end
      r_occ <= '0;
    end else if (CLR) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i] <= 1'b0;
      end
      r_occ <= '0;
    end else if (EN) begin
      r_data[0] <= D;
      r_vld[0]  <= DV;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i] <= r_data[i-1];
        r_vld[i]  <= r_vld[i-1];
      end
      r_occ <= w_occ_sum[CW-1:0];
    end
  end

  // Out-of-range selects fall through to the zero defaults.
  always_comb begin
    w_tap_q = '0;
    w_tap_v = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (TAP_SEL == TW'(i)) begin
        w_tap_q = r_data[i];
        w_tap_v = r_vld[i];
      end
    end
  end

  assign Q     = r_data[DEPTH-1];
  assign QV    = r_vld[DEPTH-1];
  assign TAP_Q = w_tap_q;
  assign TAP_V = w_tap_v;
  assign OCC   = r_occ;

endmodule

`default_nettype wire

// File: tb/tb_dff_pipe.sv
// ============================================================================
// Module   : tb_dff_pipe
// Purpose  : Directed self-checking bench for dff_pipe (DEPTH 4, 3 and 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dff_pipe;

  logic       CK = 1'b0;
  logic       RN = 1'b0;
  logic       EN = 1'b0;
  logic       CLR = 1'b0;
  logic [7:0] D = '0;
  logic       DV = 1'b0;
  logic [1:0] TAP_SEL = '0;
  logic [7:0] Q, TAP_Q;
  logic       QV, TAP_V;
  logic [2:0] OCC;

  logic [7:0] q3, tq3;
  logic       qv3, tv3;
  logic [1:0] occ3;

  logic       d1_d = 1'b0, d1_dv = 1'b0, d1_sel = 1'b0;
  logic       q1, qv1, tq1, tv1;
  logic [0:0] occ1;

  int total = 0;
  int bad   = 0;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) u_dut (
    .CK(CK), .RN(RN), .EN(EN), .CLR(CLR), .D(D), .DV(DV), .TAP_SEL(TAP_SEL),
    .Q(Q), .QV(QV), .TAP_Q(TAP_Q), .TAP_V(TAP_V), .OCC(OCC));

  dff_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h00)) u_d3 (
    .CK(CK), .RN(RN), .EN(EN), .CLR(CLR), .D(D), .DV(DV), .TAP_SEL(TAP_SEL),
    .Q(q3), .QV(qv3), .TAP_Q(tq3), .TAP_V(tv3), .OCC(occ3));

  dff_pipe #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b0)) u_d1 (
    .CK(CK), .RN(RN), .EN(EN), .CLR(CLR), .D(d1_d), .DV(d1_dv), .TAP_SEL(d1_sel),
    .Q(q1), .QV(qv1), .TAP_Q(tq1), .TAP_V(tv1), .OCC(occ1));

  always #5 CK = ~CK;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic do_reset();
    RN = 1'b0; EN = 1'b1; CLR = 1'b0; D = 8'hFF; DV = 1'b1;
    d1_d = 1'b1; d1_dv = 1'b1;
    tick();
    tick();
    RN = 1'b1; D = 8'h00; DV = 1'b0; d1_d = 1'b0; d1_dv = 1'b0;
  endtask

  logic [7:0] d_in  [1:9] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0};
  logic       dv_in [1:9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [2:0] occ_e [1:9] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd2, 3'd2, 3'd1, 3'd0, 3'd0};

  initial begin
    // Reset with hostile inputs, then a single word through the pipe
    RN = 1'b0; EN = 1'b1; D = 8'hFF; DV = 1'b1; d1_d = 1'b1; d1_dv = 1'b1;
    tick();
    tick();
    chk("rst_q", Q, 8'h00);
    chk("rst_qv", QV, 1'b0);
    chk("rst_occ", OCC, 3'd0);
    chk("rst_tapv", TAP_V, 1'b0);
    chk("rst_d1_qv", qv1, 1'b0);
    chk("rst_d1_occ", occ1, 1'b0);
    RN = 1'b1; D = 8'hA5; DV = 1'b1; d1_d = 1'b1; d1_dv = 1'b1; TAP_SEL = 2'd0;
    tick();
    chk("p1_occ_e1", OCC, 3'd1);
    chk("p1_tapq", TAP_Q, 8'hA5);
    chk("p1_tapv", TAP_V, 1'b1);
    chk("p1_d1_q", q1, 1'b1);
    chk("p1_d1_qv", qv1, 1'b1);
    chk("p1_d1_occ", occ1, 1'b1);
    D = 8'h00; DV = 1'b0; d1_d = 1'b0; d1_dv = 1'b0;
    tick();
    chk("p1_d1_qv_e2", qv1, 1'b0);
    chk("p1_d1_occ_e2", occ1, 1'b0);
    tick();
    chk("p1_qv_e3", QV, 1'b0);
    tick();
    chk("p1_q_e4", Q, 8'hA5);
    chk("p1_qv_e4", QV, 1'b1);
    chk("p1_occ_e4", OCC, 3'd1);
    tick();
    chk("p1_qv_e5", QV, 1'b0);
    chk("p1_occ_e5", OCC, 3'd0);

    // Stream with bubbles
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      D = d_in[k]; DV = dv_in[k];
      tick();
      chk($sformatf("p2_occ_%0d", k), OCC, occ_e[k]);
      if (k >= 4) begin
        chk($sformatf("p2_q_%0d", k), Q, d_in[k-3]);
        chk($sformatf("p2_qv_%0d", k), QV, dv_in[k-3]);
      end
    end

    // Stall
    do_reset();
    D = 8'h11; DV = 1'b1; tick();
    D = 8'h22; DV = 1'b1; tick();
    EN = 1'b0; D = 8'h99; DV = 1'b1; TAP_SEL = 2'd1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("p3_stall_occ_%0d", k), OCC, 3'd2);
      chk($sformatf("p3_stall_qv_%0d", k), QV, 1'b0);
      chk($sformatf("p3_stall_tap_%0d", k), TAP_Q, 8'h11);
    end
    EN = 1'b1; D = 8'h00; DV = 1'b0;
    tick();
    chk("p3_res1_qv", QV, 1'b0);
    tick();
    chk("p3_res2_q", Q, 8'h11);
    chk("p3_res2_qv", QV, 1'b1);
    chk("p3_res2_occ", OCC, 3'd2);
    tick();
    chk("p3_res3_q", Q, 8'h22);
    chk("p3_res3_occ", OCC, 3'd1);

    // Flush beats a simultaneous advance
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      D = 8'(k); DV = 1'b1; tick();
    end
    chk("p4_full_occ", OCC, 3'd4);
    CLR = 1'b1; EN = 1'b1; D = 8'h77; DV = 1'b1;
    tick();
    CLR = 1'b0; D = 8'h00; DV = 1'b0;
    chk("p4_occ", OCC, 3'd0);
    chk("p4_qv", QV, 1'b0);
    chk("p4_q_hold", Q, 8'h01);
    for (int s = 0; s < 4; s++) begin
      TAP_SEL = 2'(s); #1;
      chk($sformatf("p4_tapv_%0d", s), TAP_V, 1'b0);
    end
    TAP_SEL = 2'd0; #1;
    chk("p4_tapq0_hold", TAP_Q, 8'h04);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("p4_after_qv_%0d", k), QV, 1'b0);
    end

    // Full steady state, then reset mid-stream
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      D = 8'(k); DV = 1'b1; tick();
      chk($sformatf("p5_occ_%0d", k), OCC, (k < 4) ? 3'(k) : 3'd4);
      if (k >= 4) chk($sformatf("p5_q_%0d", k), Q, 8'(k - 3));
    end
    RN = 1'b0; tick();
    chk("p5_mrst_occ", OCC, 3'd0);
    chk("p5_mrst_qv", QV, 1'b0);
    chk("p5_mrst_q", Q, 8'h00);
    RN = 1'b1; DV = 1'b0;

    // Tap and bounds across all three depths
    do_reset();
    D = 8'h10; DV = 1'b1; d1_d = 1'b1; d1_dv = 1'b1; tick();
    D = 8'h20; tick();
    D = 8'h30; tick();
    EN = 1'b0; DV = 1'b0; d1_dv = 1'b0;
    #1; RN = 1'b0; #2; RN = 1'b1;
    tick();
    chk("p6_glitch_occ", OCC, 3'd3);
    TAP_SEL = 2'd0; #1;
    chk("p6_t0_q", TAP_Q, 8'h30);
    chk("p6_t0_v", TAP_V, 1'b1);
    TAP_SEL = 2'd1; #1;
    chk("p6_t1_q", TAP_Q, 8'h20);
    TAP_SEL = 2'd2; #1;
    chk("p6_t2_q", TAP_Q, 8'h10);
    chk("p6_t2_v", TAP_V, 1'b1);
    chk("p6_d3_tap2", tq3, 8'h10);
    TAP_SEL = 2'd3; #1;
    chk("p6_t3_v", TAP_V, 1'b0);
    chk("p6_d3_oor_q", tq3, 8'h00);
    chk("p6_d3_oor_v", tv3, 1'b0);
    chk("p6_d3_q", q3, 8'h10);
    chk("p6_d3_qv", qv3, 1'b1);
    chk("p6_d3_occ", occ3, 2'd3);
    d1_sel = 1'b0; #1;
    chk("p6_d1_t0_q", tq1, 1'b1);
    chk("p6_d1_t0_v", tv1, 1'b1);
    d1_sel = 1'b1; #1;
    chk("p6_d1_oor_q", tq1, 1'b0);
    chk("p6_d1_oor_v", tv1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
